// File: rtl/pe_result_drain_if.sv
// Bundle between the result drain, its controller, the PE writeback lanes and the store stream.
// The drain side uses the master modport; controller/PE/store side uses slave.
interface pe_result_drain_if #(
  parameter int NUM_PE       = 4,
  parameter int WORDS_PER_PE = 4,
  parameter int DATA_W       = 32,
  localparam int PE_W        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int WD_W        = (WORDS_PER_PE > 1) ? $clog2(WORDS_PER_PE) : 1
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     wben;
  logic [NUM_PE-1:0]        out_ready;
  logic [NUM_PE*DATA_W-1:0] out_sum_i;
  // Stream handshake: a word transfers on any rising clk edge with m_valid && m_ready;
  // once m_valid is raised, m_data/m_pe_idx/m_word_idx/m_last hold until that transfer.
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_data;
  logic [PE_W-1:0]          m_pe_idx;
  logic [WD_W-1:0]          m_word_idx;
  logic                     m_last;

  modport master (
    input  start, out_sum_i, m_ready,
    output busy, done, wben, out_ready, m_valid, m_data, m_pe_idx, m_word_idx, m_last
  );

  modport slave (
    output start, out_sum_i, m_ready,
    input  busy, done, wben, out_ready, m_valid, m_data, m_pe_idx, m_word_idx, m_last
  );
endinterface

// File: rtl/pe_result_drain.sv
// Drains the accumulator regfiles of one systolic column, PE by PE, onto a valid/ready stream.
// Optional macro PE_DRAIN_TRACE_EN adds a simulation trace of accepted words and a word counter.
module pe_result_drain #(
  parameter int NUM_PE       = 4,
  parameter int WORDS_PER_PE = 4,
  parameter int DATA_W       = 32,
  localparam int PE_W        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int WD_W        = (WORDS_PER_PE > 1) ? $clog2(WORDS_PER_PE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  pe_result_drain_if.master   bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CAPT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [PE_W-1:0] PE_LAST = PE_W'(NUM_PE - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WORDS_PER_PE - 1);

  state_e            state_q, state_d;
  logic [PE_W-1:0]   pe_cnt_q, pe_cnt_d;
  logic [WD_W-1:0]   word_cnt_q, word_cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [PE_W-1:0]   m_pe_idx_q, m_pe_idx_d;
  logic [WD_W-1:0]   m_word_idx_q, m_word_idx_d;
  logic              m_last_q, m_last_d;

  logic              busy, done, wben;
  logic [NUM_PE-1:0] out_ready;
  logic [DATA_W-1:0] lanes [NUM_PE];

  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      lanes[k] = bus.out_sum_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pe_cnt_q     <= '0;
      word_cnt_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_pe_idx_q   <= '0;
      m_word_idx_q <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pe_cnt_q     <= pe_cnt_d;
      word_cnt_q   <= word_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_pe_idx_q   <= m_pe_idx_d;
      m_word_idx_q <= m_word_idx_d;
      m_last_q     <= m_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pe_cnt_d     = pe_cnt_q;
    word_cnt_d   = word_cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_pe_idx_d   = m_pe_idx_q;
    m_word_idx_d = m_word_idx_q;
    m_last_d     = m_last_q;
    busy         = 1'b0;
    done         = 1'b0;
    wben         = 1'b0;
    out_ready    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_ISSUE;
          pe_cnt_d   = '0;
          word_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        busy      = 1'b1;
        wben      = 1'b1;
        out_ready = NUM_PE'(1) << pe_cnt_q;
        state_d   = S_CAPT;
      end
      S_CAPT: begin
        // The PE registered its word on the strobe edge, so the lane is valid now.
        busy         = 1'b1;
        wben         = 1'b1;
        m_data_d     = lanes[pe_cnt_q];
        m_pe_idx_d   = pe_cnt_q;
        m_word_idx_d = word_cnt_q;
        m_last_d     = (pe_cnt_q == PE_LAST) && (word_cnt_q == WD_LAST);
        m_valid_d    = 1'b1;
        state_d      = S_PUSH;
      end
      S_PUSH: begin
        busy = 1'b1;
        wben = 1'b1;
        if (m_valid_q && bus.m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = S_DONE;
          end else begin
            if (word_cnt_q == WD_LAST) begin
              word_cnt_d = '0;
              pe_cnt_d   = pe_cnt_q + 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.wben       = wben;
  assign bus.out_ready  = out_ready;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_pe_idx   = m_pe_idx_q;
  assign bus.m_word_idx = m_word_idx_q;
  assign bus.m_last     = m_last_q;
  assign dbg_state_o    = state_q;

`ifdef PE_DRAIN_TRACE_EN
  localparam int CNT_W = $clog2(NUM_PE * WORDS_PER_PE + 1);
  logic [CNT_W-1:0] trace_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        trace_cnt_q <= '0;
      end else if (m_valid_q && bus.m_ready) begin
        trace_cnt_q <= trace_cnt_q + 1'b1;
        $display("DRAIN PE%0d[%0d]:%h", m_pe_idx_q, m_word_idx_q, m_data_q);
      end
      if (state_q == S_DONE) begin
        $display("DRAIN done %0d words", trace_cnt_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: PE regfile model, scoreboard on the output stream, directed scenarios.
module tb_pe_result_drain;
  localparam int NUM_PE = 4;
  localparam int WPP    = 4;
  localparam int DATA_W = 32;
  localparam int PE_W   = 2;
  localparam int WD_W   = 2;
  localparam int EW     = PE_W + WD_W + DATA_W + 1;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  pe_result_drain_if #(.NUM_PE(NUM_PE), .WORDS_PER_PE(WPP), .DATA_W(DATA_W)) bus ();

  pe_result_drain #(.NUM_PE(NUM_PE), .WORDS_PER_PE(WPP), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PE regfile model ----------------
  logic [DATA_W-1:0] pe_mem [NUM_PE][WPP];
  logic [WD_W-1:0]   ptr    [NUM_PE];
  logic [DATA_W-1:0] sum_q  [NUM_PE];

  always @(posedge clk) begin
    for (int k = 0; k < NUM_PE; k++) begin
      if (rst) begin
        ptr[k]   <= '0;
        sum_q[k] <= '0;
      end else if (bus.wben && bus.out_ready[k]) begin
        sum_q[k] <= pe_mem[k][ptr[k]];
        ptr[k]   <= ptr[k] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      bus.out_sum_i[k*DATA_W +: DATA_W] = sum_q[k];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int wben_cnt = 0;
  int strobe_cnt [NUM_PE];
  int ready_mode = 0;
  int bp_cnt     = 0;
  bit hold_prev  = 1'b0;
  logic [EW-1:0] prev_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     bus.busy,       0);
    check({tag, "_done"},     bus.done,       0);
    check({tag, "_wben"},     bus.wben,       0);
    check({tag, "_out_rdy"},  bus.out_ready,  0);
    check({tag, "_m_valid"},  bus.m_valid,    0);
    check({tag, "_m_data"},   bus.m_data,     0);
    check({tag, "_m_pe"},     bus.m_pe_idx,   0);
    check({tag, "_m_word"},   bus.m_word_idx, 0);
    check({tag, "_m_last"},   bus.m_last,     0);
    check({tag, "_state"},    dbg_state,      0);
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          if (bus.m_valid && bus.m_pe_idx == 2'd1 && bus.m_word_idx == 2'd2 && bp_cnt < 5) begin
            bus.m_ready = 1'b0;
            bp_cnt++;
          end else begin
            bus.m_ready = 1'b1;
          end
        end
        2:       bus.m_ready = ($urandom_range(0, 3) != 0);
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] exp_w;
    cur = {bus.m_pe_idx, bus.m_word_idx, bus.m_data, bus.m_last};
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (bus.out_ready != '0) begin
        check("strobe_onehot", $onehot(bus.out_ready), 1);
        check("strobe_wben", bus.wben, 1);
        check("strobe_while_valid", bus.m_valid, 0);
        for (int k = 0; k < NUM_PE; k++) if (bus.out_ready[k]) strobe_cnt[k]++;
      end
      if (bus.wben) wben_cnt++;
      check("wben_vs_busy", bus.wben, bus.busy);
      if (hold_prev) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_word", cur, prev_word);
      end
      hold_prev = bus.m_valid && !bus.m_ready;
      prev_word = cur;
      if (bus.m_valid && bus.m_ready) begin
        acc_cnt++;
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("word", cur, exp_w);
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  // ---------------- drain driver ----------------
  task automatic run_drain(input bit pre_started, input bit extra_start, input bit rst_at6,
                           input bit chain_next, input int exp_lat, input int exp_wben);
    int  cyc;
    int  first_v;
    int  acc0;
    int  done0;
    bit  got_done;
    if (!pre_started) begin
      @(posedge clk);
      #1;
      bus.start = 1'b1;
    end
    for (int k = 0; k < NUM_PE; k++) begin
      for (int w = 0; w < WPP; w++) begin
        exp_q.push_back({PE_W'(k), WD_W'(w), pe_mem[k][w], (k == NUM_PE-1) && (w == WPP-1)});
      end
    end
    for (int k = 0; k < NUM_PE; k++) strobe_cnt[k] = 0;
    wben_cnt = 0;
    acc0     = acc_cnt;
    done0    = done_cnt;
    first_v  = -1;
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (extra_start && cyc == 10) bus.start = 1'b1;
      if (extra_start && cyc == 11) bus.start = 1'b0;
      if (first_v < 0 && bus.m_valid) first_v = cyc;
      if (rst_at6 && bus.m_valid && (acc_cnt - acc0) == 5) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        exp_q.delete();
        return;
      end
      if (bus.done) got_done = 1'b1;
    end
    check("done_seen", got_done, 1);
    if (exp_lat >= 0) check("done_latency", cyc, exp_lat);
    check("first_valid", first_v, 3);
    if (chain_next) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("start_in_done_busy", bus.busy, 0);
      check("start_in_done_state", dbg_state, 0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_done", bus.busy, 0);
    end
    check("done_pulses", done_cnt - done0, 1);
    check("words_accepted", acc_cnt - acc0, NUM_PE * WPP);
    check("exp_q_drained", exp_q.size(), 0);
    for (int k = 0; k < NUM_PE; k++) check("strobes_per_lane", strobe_cnt[k], WPP);
    if (exp_wben >= 0) check("wben_cycles", wben_cnt, exp_wben);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    for (int k = 0; k < NUM_PE; k++) begin
      for (int w = 0; w < WPP; w++) pe_mem[k][w] = 32'hA000_0000 + 32'(16 * k + w);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic drain, ready tied high
    run_drain(1'b0, 1'b0, 1'b0, 1'b0, 49, 48);

    // 5-cycle stall on PE1 word2
    bp_cnt     = 0;
    ready_mode = 1;
    run_drain(1'b0, 1'b0, 1'b0, 1'b0, 54, 53);
    check("bp_stall_cycles", bp_cnt, 5);
    ready_mode = 0;

    // start pulse while busy
    run_drain(1'b0, 1'b1, 1'b0, 1'b0, 49, 48);

    // reset during the sixth word, then a fresh full drain
    run_drain(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    run_drain(1'b0, 1'b0, 1'b0, 1'b0, 49, 48);

    // start during done (ignored) held into the next cycle: back-to-back drains
    run_drain(1'b0, 1'b0, 1'b0, 1'b1, 49, 48);
    run_drain(1'b1, 1'b0, 1'b0, 1'b0, 49, 48);

    // random data with random backpressure
    for (int k = 0; k < NUM_PE; k++) begin
      for (int w = 0; w < WPP; w++) pe_mem[k][w] = $urandom;
    end
    ready_mode = 2;
    run_drain(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    ready_mode = 0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
